// File: rtl/decode_queue_ctrl_pkg.sv
// Shared RISC-V decode definitions: base opcodes, immediate formats and the
// queue entry layout used by the decode-side instruction queue.
package decode_queue_ctrl_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   typedef enum logic [2:0] {
      FMT_R,
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J,
      FMT_ILL
   } imm_fmt_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] imm;
      imm_fmt_e    fmt;
   } entry_t;

endpackage

// File: rtl/decode_queue_ctrl_imm_ext.sv
// Immediate extraction and sign extension for each RISC-V immediate format.
// R-type and unrecognised opcodes produce zero.
module imm_extension_unit
   import decode_queue_ctrl_pkg::*;
(
   input  logic [31:7] instr,
   input  imm_fmt_e    fmt,
   output logic [31:0] imm
);

   // NOTE: every always_comb output gets a default before the case so that no
   // path leaves it unassigned and a latch is inferred.
   always_comb begin
      imm = '0;
      case (fmt)
         FMT_I: imm = {{20{instr[31]}}, instr[31:20]};
         FMT_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         FMT_U: imm = {instr[31:12], 12'b0};
         FMT_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/decode_queue_ctrl.sv
// Decode-side instruction queue: classifies and extends immediates at enqueue,
// buffers DEPTH entries and presents the head entry to execute.
module decode_queue_ctrl
   import decode_queue_ctrl_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        flush_i,
   input  logic        instr_valid_i,
   output logic        instr_ready_o,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   output logic        dec_valid_o,
   input  logic        dec_ready_i,
   output logic [31:0] dec_instr_o,
   output logic [31:0] dec_pc_o,
   output logic [31:0] dec_imm_o,
   output imm_fmt_e    dec_fmt_o,
   output logic        dec_illegal_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   entry_t             mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   imm_fmt_e           enq_fmt;
   logic [31:0]        enq_imm;
   logic               enq;
   logic               deq;

   always_comb begin
      enq_fmt = FMT_ILL;
      case (instr_i[6:0])
         OPC_LOAD, OPC_OP_IMM, OPC_JALR: enq_fmt = FMT_I;
         OPC_STORE:                      enq_fmt = FMT_S;
         OPC_BRANCH:                     enq_fmt = FMT_B;
         OPC_JAL:                        enq_fmt = FMT_J;
         OPC_LUI, OPC_AUIPC:             enq_fmt = FMT_U;
         OPC_OP:                         enq_fmt = FMT_R;
         default:                        enq_fmt = FMT_ILL;
      endcase
   end

   imm_extension_unit u_imm_ext (
      .instr (instr_i[31:7]),
      .fmt   (enq_fmt),
      .imm   (enq_imm)
   );

   // Ready depends only on registered count, never on dec_ready_i.
   assign instr_ready_o = (count != FULL_CNT);
   assign dec_valid_o   = (count != '0);
   assign enq           = instr_valid_i & instr_ready_o & ~flush_i;
   assign deq           = dec_valid_o & dec_ready_i & ~flush_i;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
         if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({enq, deq})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; count gates visibility, so stale
   // contents can never reach the outputs.
   always_ff @(posedge clk_i) begin
      if (enq) mem[wr_ptr] <= '{instr: instr_i, pc: pc_i, imm: enq_imm, fmt: enq_fmt};
   end

   always_comb begin
      dec_instr_o   = '0;
      dec_pc_o      = '0;
      dec_imm_o     = '0;
      dec_fmt_o     = FMT_R;
      dec_illegal_o = 1'b0;
      if (dec_valid_o) begin
         dec_instr_o   = mem[rd_ptr].instr;
         dec_pc_o      = mem[rd_ptr].pc;
         dec_imm_o     = mem[rd_ptr].imm;
         dec_fmt_o     = mem[rd_ptr].fmt;
         dec_illegal_o = (mem[rd_ptr].fmt == FMT_ILL);
      end
   end

endmodule

// File: tb/tb_decode_queue_ctrl.sv
// Self-checking bench for decode_queue_ctrl: vector table of instructions with
// expected immediates, driven through a queue model with a scoreboard.
module tb_decode_queue_ctrl;
   import decode_queue_ctrl_pkg::*;

   localparam int DEPTH = 2;
   localparam int NVEC  = 13;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] imm;
      imm_fmt_e    fmt;
      logic        ill;
   } vec_t;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        flush_i = 1'b0;
   logic        instr_valid_i = 1'b0;
   logic        instr_ready_o;
   logic [31:0] instr_i = '0;
   logic [31:0] pc_i = '0;
   logic        dec_valid_o;
   logic        dec_ready_i = 1'b0;
   logic [31:0] dec_instr_o;
   logic [31:0] dec_pc_o;
   logic [31:0] dec_imm_o;
   imm_fmt_e    dec_fmt_o;
   logic        dec_illegal_o;

   vec_t vecs [NVEC];
   vec_t sb [$];
   int   n_checks = 0;
   int   n_fail   = 0;

   decode_queue_ctrl #(.DEPTH(DEPTH)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .flush_i       (flush_i),
      .instr_valid_i (instr_valid_i),
      .instr_ready_o (instr_ready_o),
      .instr_i       (instr_i),
      .pc_i          (pc_i),
      .dec_valid_o   (dec_valid_o),
      .dec_ready_i   (dec_ready_i),
      .dec_instr_o   (dec_instr_o),
      .dec_pc_o      (dec_pc_o),
      .dec_imm_o     (dec_imm_o),
      .dec_fmt_o     (dec_fmt_o),
      .dec_illegal_o (dec_illegal_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare DUT outputs against the model (sb holds queued entries, head first).
   task automatic check_outputs(input string tag);
      check({tag, " instr_ready"}, 32'(instr_ready_o), 32'(sb.size() != DEPTH));
      check({tag, " dec_valid"}, 32'(dec_valid_o), 32'(sb.size() != 0));
      if (sb.size() != 0) begin
         check({tag, " dec_instr"}, dec_instr_o, sb[0].instr);
         check({tag, " dec_pc"}, dec_pc_o, sb[0].pc);
         check({tag, " dec_imm"}, dec_imm_o, sb[0].imm);
         check({tag, " dec_fmt"}, 32'(dec_fmt_o), 32'(sb[0].fmt));
         check({tag, " dec_illegal"}, 32'(dec_illegal_o), 32'(sb[0].ill));
      end else begin
         check({tag, " idle data"}, dec_instr_o | dec_pc_o | dec_imm_o, 32'h0);
         check({tag, " idle fmt/ill"}, {28'h0, dec_illegal_o, dec_fmt_o}, 32'h0);
      end
   endtask

   // One clock cycle: drive inputs, check mid-cycle, advance the model at the edge.
   task automatic cycle(input string tag, input logic v, input vec_t e,
                        input logic rdy, input logic fl);
      logic acc, dq;
      instr_valid_i = v;
      instr_i       = e.instr;
      pc_i          = e.pc;
      dec_ready_i   = rdy;
      flush_i       = fl;
      @(negedge clk_i);
      check_outputs(tag);
      acc = v && (sb.size() != DEPTH) && !fl;
      dq  = rdy && (sb.size() != 0) && !fl;
      if (fl) sb.delete();
      else begin
         if (dq) void'(sb.pop_front());
         if (acc) sb.push_back(e);
      end
      @(posedge clk_i);
      #1;
   endtask

   function automatic vec_t mk(input logic [31:0] ins, input logic [31:0] pc,
                               input logic [31:0] imm, input imm_fmt_e fmt);
      vec_t r;
      r.instr = ins;
      r.pc    = pc;
      r.imm   = imm;
      r.fmt   = fmt;
      r.ill   = (fmt == FMT_ILL);
      return r;
   endfunction

   initial begin
      vec_t idle;
      vecs[0]  = mk(32'hFFF00093, 32'h0000_0000, 32'hFFFF_FFFF, FMT_I);
      vecs[1]  = mk(32'hFE112E23, 32'h0000_0004, 32'hFFFF_FFFC, FMT_S);
      vecs[2]  = mk(32'hFE000CE3, 32'h0000_0008, 32'hFFFF_FFF8, FMT_B);
      vecs[3]  = mk(32'h123452B7, 32'h0000_000C, 32'h1234_5000, FMT_U);
      vecs[4]  = mk(32'h001000EF, 32'h0000_0010, 32'h0000_0800, FMT_J);
      vecs[5]  = mk(32'h00412083, 32'h0000_0014, 32'h0000_0004, FMT_I);
      vecs[6]  = mk(32'h000080E7, 32'h0000_0018, 32'h0000_0000, FMT_I);
      vecs[7]  = mk(32'hFFFFF097, 32'h0000_001C, 32'hFFFF_F000, FMT_U);
      vecs[8]  = mk(32'h002081B3, 32'h0000_0020, 32'h0000_0000, FMT_R);
      vecs[9]  = mk(32'h00208463, 32'h0000_0024, 32'h0000_0008, FMT_B);
      vecs[10] = mk(32'hFFDFF0EF, 32'h0000_0028, 32'hFFFF_FFFC, FMT_J);
      vecs[11] = mk(32'h00112223, 32'h0000_002C, 32'h0000_0004, FMT_S);
      vecs[12] = mk(32'h0000007F, 32'h0000_0030, 32'h0000_0000, FMT_ILL);
      idle = mk(32'h0, 32'h0, 32'h0, FMT_R);

      // Reset state
      repeat (2) @(posedge clk_i);
      #2;
      check("reset dec_valid", 32'(dec_valid_o), 32'h0);
      check("reset data", dec_instr_o | dec_pc_o | dec_imm_o, 32'h0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      cycle("post-reset", 1'b0, idle, 1'b0, 1'b0);

      // Table: stream every vector with execute always ready
      for (int i = 0; i < NVEC; i++) cycle($sformatf("vec%0d", i), 1'b1, vecs[i], 1'b1, 1'b0);
      cycle("drain", 1'b0, idle, 1'b1, 1'b0);
      cycle("empty", 1'b0, idle, 1'b1, 1'b0);

      // Backpressure: third instr held by fetch, full+ready refuses enqueue
      cycle("bp0", 1'b1, vecs[1], 1'b0, 1'b0);
      cycle("bp1", 1'b1, vecs[2], 1'b0, 1'b0);
      cycle("bp2 full", 1'b1, vecs[3], 1'b0, 1'b0);
      cycle("bp3 full", 1'b1, vecs[3], 1'b0, 1'b0);
      cycle("full deq", 1'b1, vecs[3], 1'b1, 1'b0);
      cycle("enq+deq", 1'b1, vecs[3], 1'b1, 1'b0);
      cycle("bp last", 1'b0, idle, 1'b1, 1'b0);
      cycle("bp empty", 1'b0, idle, 1'b1, 1'b0);

      // Flush with two queued entries and a same-cycle offer
      cycle("fl0", 1'b1, vecs[5], 1'b0, 1'b0);
      cycle("fl1", 1'b1, vecs[6], 1'b0, 1'b0);
      cycle("flush", 1'b1, vecs[7], 1'b1, 1'b1);
      cycle("post-flush", 1'b1, vecs[8], 1'b0, 1'b0);
      cycle("post-flush head", 1'b0, idle, 1'b1, 1'b0);
      cycle("post-flush empty", 1'b0, idle, 1'b0, 1'b0);

      // Illegal opcode then asynchronous reset mid-stream
      cycle("ill", 1'b1, vecs[12], 1'b0, 1'b0);
      cycle("ill2", 1'b1, vecs[4], 1'b0, 1'b0);
      instr_valid_i = 1'b0;
      #2;
      rst_ni = 1'b0;
      #1;
      check("async rst dec_valid", 32'(dec_valid_o), 32'h0);
      check("async rst data", dec_instr_o | dec_imm_o, 32'h0);
      sb.delete();
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      cycle("after rst", 1'b1, vecs[9], 1'b0, 1'b0);
      cycle("after rst head", 1'b0, idle, 1'b1, 1'b0);

      // Random traffic with occasional flush
      for (int i = 0; i < 300; i++) begin
         vec_t e;
         e = vecs[$urandom_range(0, NVEC - 1)];
         e.pc = $urandom;
         cycle("rand", 1'($urandom_range(0, 1)), e, 1'($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 19) == 0));
      end
      cycle("final", 1'b0, idle, 1'b1, 1'b1);
      cycle("final empty", 1'b0, idle, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
